rtc_irq_ctrl: RTL

- Interrupt status/enable stage directly downstream of the clock/PRAM block.
- Consumes its onesecond_irq and qtrsecond_irq single-cycle pulses, plus the video VBL-start and scanline pulses.
- Latches them into IIgs-compatible status registers ($C023, $C032, $C041, $C046, $C047) and drives a registered, active-low CPU IRQ line.
- Sits on the same $C0xx I/O strobe bus as the clock block.

---
 rtl/rtc_irq_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/rtc_irq_ctrl.sv
// rtc_irq_ctrl
//   IIgs-compatible interrupt status/enable stage. It sits after the
//   clock/PRAM block on the shared $C0xx strobe bus. It latches the one-second,
//   quarter-second, VBL-start and scanline pulses into status bits, and those
//   bits are gated by their enables. It also drives a registered, active-low
//   CPU IRQ.
//
// Ports
//   CLK_14M        system clock (14.318 MHz)
//   reset_n        asynchronous active-low reset
//   cen            bus clock enable
//   strobe         bus access, high for one cen cycle per access
//   rw             1 = read, 0 = write
//   addr[7:0]      low byte of the $C0xx address
//   din[7:0]       write data
//   dout[7:0]      combinational read data
//   sel            combinational, high for $23/$32/$41/$46/$47
//   onesecond_irq  one-cycle pulse from the clock block
//   qtrsecond_irq  one-cycle pulse from the clock block
//   vbl_start      one-cycle pulse at VBL start
//   scanline_irq   one-cycle pulse at a flagged scanline
//   irq_n          registered CPU IRQ, active low
module rtc_irq_ctrl #(
  parameter int unsigned QSEC_EN_BIT = 4,
  parameter int unsigned VBL_EN_BIT  = 3
) (
  input  logic       CLK_14M,
  input  logic       reset_n,
  input  logic       cen,
  input  logic       strobe,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       sel,
  input  logic       onesecond_irq,
  input  logic       qtrsecond_irq,
  input  logic       vbl_start,
  input  logic       scanline_irq,
  output logic       irq_n
);

  localparam logic [7:0] A_VGCINT = 8'h23;
  localparam logic [7:0] A_SCNCLR = 8'h32;
  localparam logic [7:0] A_INTEN  = 8'h41;
  localparam logic [7:0] A_INTFLG = 8'h46;
  localparam logic [7:0] A_INTCLR = 8'h47;

  logic en_sec_q,  en_sec_d;
  logic en_scan_q, en_scan_d;
  logic en_qsec_q, en_qsec_d;
  logic en_vbl_q,  en_vbl_d;
  logic st_sec_q,  st_sec_d;
  logic st_scan_q, st_scan_d;
  logic st_qsec_q, st_qsec_d;
  logic st_vbl_q,  st_vbl_d;
  logic irq_n_q,   irq_n_d;

  logic access, wr;
  logic vgc_pend;
  logic unused_din;

  // Only a subset of din bits is stored at any address.
  assign unused_din = ^din;

  assign access   = strobe & cen;
  assign wr       = access & ~rw;
  assign vgc_pend = (st_sec_q & en_sec_q) | (st_scan_q & en_scan_q);

  always_comb begin
    en_sec_d  = en_sec_q;
    en_scan_d = en_scan_q;
    en_qsec_d = en_qsec_q;
    en_vbl_d  = en_vbl_q;
    st_sec_d  = st_sec_q;
    st_scan_d = st_scan_q;
    st_qsec_d = st_qsec_q;
    st_vbl_d  = st_vbl_q;

    if (wr && addr == A_VGCINT) begin
      en_sec_d  = din[2];
      en_scan_d = din[1];
    end
    if (wr && addr == A_INTEN) begin
      en_qsec_d = din[QSEC_EN_BIT];
      en_vbl_d  = din[VBL_EN_BIT];
    end

    // Clears are applied first so that a same-cycle event pulse wins.
    if (wr && addr == A_SCNCLR) begin
      if (!din[6]) st_sec_d  = 1'b0;
      if (!din[5]) st_scan_d = 1'b0;
    end
    if (access && addr == A_INTCLR) begin
      st_qsec_d = 1'b0;
      st_vbl_d  = 1'b0;
    end

    if (onesecond_irq && en_sec_q)  st_sec_d  = 1'b1;
    if (scanline_irq  && en_scan_q) st_scan_d = 1'b1;
    if (qtrsecond_irq && en_qsec_q) st_qsec_d = 1'b1;
    if (vbl_start     && en_vbl_q)  st_vbl_d  = 1'b1;

    // Built from the current state, so irq_n trails the status change by one edge.
    irq_n_d = ~((st_sec_q  & en_sec_q)  | (st_scan_q & en_scan_q) |
                (st_qsec_q & en_qsec_q) | (st_vbl_q  & en_vbl_q));
  end

  always_ff @(posedge CLK_14M or negedge reset_n) begin
    if (!reset_n) begin
      en_sec_q  <= 1'b0;
      en_scan_q <= 1'b0;
      en_qsec_q <= 1'b0;
      en_vbl_q  <= 1'b0;
      st_sec_q  <= 1'b0;
      st_scan_q <= 1'b0;
      st_qsec_q <= 1'b0;
      st_vbl_q  <= 1'b0;
      irq_n_q   <= 1'b1;
    end else begin
      en_sec_q  <= en_sec_d;
      en_scan_q <= en_scan_d;
      en_qsec_q <= en_qsec_d;
      en_vbl_q  <= en_vbl_d;
      st_sec_q  <= st_sec_d;
      st_scan_q <= st_scan_d;
      st_qsec_q <= st_qsec_d;
      st_vbl_q  <= st_vbl_d;
      irq_n_q   <= irq_n_d;
    end
  end

  always_comb begin
    sel  = 1'b0;
    dout = '0;
    unique case (addr)
      A_VGCINT, A_SCNCLR, A_INTEN, A_INTFLG, A_INTCLR: sel = 1'b1;
      default: sel = 1'b0;
    endcase
    if (rw) begin
      unique case (addr)
        A_VGCINT: dout = {vgc_pend, st_sec_q, st_scan_q, 2'b00,
                          en_sec_q, en_scan_q, 1'b0};
        A_INTEN: begin
          dout[QSEC_EN_BIT] = en_qsec_q;
          dout[VBL_EN_BIT]  = en_vbl_q;
        end
        A_INTFLG: begin
          dout[QSEC_EN_BIT] = st_qsec_q;
          dout[VBL_EN_BIT]  = st_vbl_q;
          dout[0]           = ~irq_n_q;
        end
        default: dout = '0;
      endcase
    end
  end

  assign irq_n = irq_n_q;

endmodule
